// File: rtl/rs_box_pkg.sv
// rtl/rs_box_pkg.sv - constants and GF(2^4) helpers for the composite-field AES S-box
package rs_box_pkg;

    localparam logic [3:0] LAMBDA   = 4'hC;
    localparam logic [7:0] AFFINE_C = 8'h63;
    // x^4 = x + 1 reduction term for x^4+x+1
    localparam logic [3:0] GF4_RED  = 4'h3;

    // Row i gives output bit i as the parity of (row & input).
    // Isomorphism GF(2^8) -> GF((2^4)^2); its columns are the powers of the root 0x21 of the AES polynomial.
    localparam logic [7:0] DELTA [8] = '{
        8'h03, 8'hA8, 8'h5C, 8'h68, 8'h70, 8'hD2, 8'hAC, 8'hA0
    };

    // Inverse isomorphism followed by the affine matrix, folded into one matrix
    localparam logic [7:0] INV_AFFINE [8] = '{
        8'hF5, 8'hDF, 8'h49, 8'h95, 8'h5B, 8'h3E, 8'hD0, 8'hC6
    };

    // Multiplicative inverse in GF(2^4); entry 0 maps to 0 so a zero input yields 0x63
    localparam logic [3:0] GF4_INV [16] = '{
        4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
        4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8
    };

    function automatic logic [3:0] gf4_sq(input logic [3:0] a);
        return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
    endfunction

    function automatic logic [3:0] gf4_mul_lambda(input logic [3:0] a);
        logic [3:0] p;
        logic [3:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (LAMBDA[i]) p = p ^ t;
            t = {t[2:0], 1'b0} ^ (t[3] ? GF4_RED : 4'h0);
        end
        return p;
    endfunction

endpackage

// File: rtl/rs_box_gf4_mul.sv
// rtl/rs_box_gf4_mul.sv - combinational GF(2^4) multiplier modulo x^4+x+1
module gf4_mul
    import rs_box_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] p
);

    logic [3:0] t;

    always_comb begin
        p = '0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[2:0], 1'b0} ^ (t[3] ? GF4_RED : 4'h0);
        end
    end

endmodule

// File: rtl/rs_box.sv
// rtl/rs_box.sv - AES forward S-box via GF((2^4)^2) inversion, one registered stage
module rs_box
    import rs_box_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] inputbyte,
    output logic [7:0] outputbyte
);

    logic [7:0] mapped;
    logic [3:0] ah;
    logic [3:0] al;
    logic [3:0] ah_al;
    logic [3:0] ah_xor_al;
    logic [3:0] d;
    logic [3:0] d_inv;
    logic [3:0] inv_hi;
    logic [3:0] inv_lo;
    logic [7:0] sbox;

    always_comb begin
        mapped = '0;
        for (int i = 0; i < 8; i++) mapped[i] = ^(DELTA[i] & inputbyte);
    end

    assign ah        = mapped[7:4];
    assign al        = mapped[3:0];
    assign ah_xor_al = ah ^ al;

    gf4_mul u_mul_ah_al (.a(ah),        .b(al),    .p(ah_al));
    gf4_mul u_mul_hi    (.a(ah),        .b(d_inv), .p(inv_hi));
    gf4_mul u_mul_lo    (.a(ah_xor_al), .b(d_inv), .p(inv_lo));

    // Norm of ah*y + al over y^2 + y + lambda
    assign d     = gf4_mul_lambda(gf4_sq(ah)) ^ ah_al ^ gf4_sq(al);
    assign d_inv = GF4_INV[d];

    always_comb begin
        sbox = '0;
        for (int i = 0; i < 8; i++) sbox[i] = ^(INV_AFFINE[i] & {inv_hi, inv_lo});
        sbox = sbox ^ AFFINE_C;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) outputbyte <= '0;
        else        outputbyte <= sbox;
    end

endmodule

// File: tb/tb_rs_box.sv
// tb/tb_rs_box.sv - scoreboard bench for rs_box
module tb_rs_box;

    logic       clk;
    logic       rst_n;
    logic [7:0] inputbyte;
    logic [7:0] outputbyte;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    localparam logic [7:0] SBOX_REF [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [7:0] DIAG_IN  [16] = '{
        8'h0f,8'h1e,8'h2d,8'h3c,8'h4b,8'h5a,8'h69,8'h78,8'h87,8'h96,8'ha5,8'hb4,8'hc3,8'hd2,8'he1,8'hf0
    };
    localparam logic [7:0] DIAG_EXP [16] = '{
        8'h76,8'h72,8'hd8,8'heb,8'hb3,8'hbe,8'hf9,8'hbc,8'h17,8'h90,8'h06,8'h8d,8'h2e,8'hb5,8'hf8,8'h8c
    };
    localparam logic [7:0] CORNER_IN  [4] = '{8'h01, 8'h53, 8'hff, 8'h80};
    localparam logic [7:0] CORNER_EXP [4] = '{8'h7c, 8'hed, 8'h16, 8'hcd};

    rs_box dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inputbyte  (inputbyte),
        .outputbyte (outputbyte)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: outputbyte=%02h expected=%02h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] e);
        @(negedge clk);
        inputbyte = b;
        exp_q.push_back(e);
    endtask

    // Monitor: one result per edge while anything is outstanding; recheck after the input has moved
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stream", outputbyte, e);
                #5;
                check("hold_mid", outputbyte, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        inputbyte = 8'h55;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async", outputbyte, 8'h00);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", outputbyte, 8'h00);
        end
        inputbyte = 8'h00;
        exp_q.push_back(8'h63);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) send(DIAG_IN[i], DIAG_EXP[i]);
        for (int i = 0; i < 4; i++)  send(CORNER_IN[i], CORNER_EXP[i]);

        for (int i = 0; i < 256; i++) send(8'(i), SBOX_REF[i]);

        repeat (5) send(8'h00, 8'h63);
        send(8'h10, 8'hca);

        // Reset pulse between edges while streaming
        for (int i = 0; i < 8; i++) begin
            send(8'h20 + 8'(i * 7), SBOX_REF[8'h20 + 8'(i * 7)]);
            if (i == 3) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rst_midstream", outputbyte, 8'h00);
                #1;
                rst_n = 1'b1;
            end
        end

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #2;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
